// File: rtl/reg_commit_ctrl.sv
// Register-file commit controller.
// Retire requests from the ROB enter an in-order queue of {reg_id, data, rob_entry}.
// The head entry is committed to the register file one entry per cycle.
// A misprediction flush drains the queue, then pulses a rename-state clear, and
// returns to normal operation. While a flush is in progress, new issue is stalled.
module reg_commit_ctrl #(
    parameter int ROB_BIT = 4,
    parameter int DEPTH   = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   in_valid,
    input  logic [4:0]             in_reg_id,
    input  logic [31:0]            in_data,
    input  logic [ROB_BIT-1:0]     in_rob_entry,
    output logic                   in_ready,
    input  logic                   flush_req,
    output logic                   rob_commit,
    output logic [4:0]             commit_reg_id,
    output logic [31:0]            commit_reg_data,
    output logic [ROB_BIT-1:0]     commit_rob_entry,
    output logic                   rob_clear_up,
    output logic                   issue_stall,
    output logic                   flush_done,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    // The three states are: normal operation, draining after a flush,
    // and a single rename-clear cycle.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    typedef struct packed {
        logic [4:0]         reg_id;
        logic [31:0]        data;
        logic [ROB_BIT-1:0] rob_entry;
    } entry_t;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

    logic   push;
    logic   pop;
    entry_t wr_entry;
    entry_t head;
    entry_t entry_arr [DEPTH];

    // Handshake: requests are accepted only in normal operation with room left.
    assign in_ready = rdy_in && (state_reg == IDLE) && (occ_reg < DEPTH_OCC);

    // Register 0 is hard-wired, so such retires are acknowledged but never queued.
    assign push = in_valid && in_ready && (in_reg_id != 5'd0);

    // The head is committed on every ready cycle except during the clear cycle.
    // A pushed entry only becomes visible after the occupancy register counts it,
    // so there is no same-cycle bypass from in_* to commit_*.
    assign rob_commit = rdy_in && (occ_reg != '0) && (state_reg != CLEAR);
    assign pop        = rob_commit;

    assign rob_clear_up = rdy_in && (state_reg == CLEAR);
    assign flush_done   = rdy_in && (state_reg == CLEAR);
    assign issue_stall  = (state_reg != IDLE);
    assign occupancy    = occ_reg;

    assign wr_entry = {in_reg_id, in_data, in_rob_entry};

    // Queue storage: one register slot per entry, written when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            entry_t entry_reg;
            logic   wr_en;

            assign wr_en = push && (wr_ptr_reg == PTR_W'(gi));

            // Capture the retire request into this slot.
            always_ff @(posedge clk_in) begin
                if (wr_en) begin
                    entry_reg <= wr_entry;
                end
            end

            assign entry_arr[gi] = entry_reg;
        end
    endgenerate

    assign head = entry_arr[rd_ptr_reg];

    // Commit fields show the head only while committing, and are zero otherwise.
    always_comb begin
        commit_reg_id    = '0;
        commit_reg_data  = '0;
        commit_rob_entry = '0;
        if (rob_commit) begin
            commit_reg_id    = head.reg_id;
            commit_reg_data  = head.data;
            commit_rob_entry = head.rob_entry;
        end
    end

    // Occupancy after this cycle; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_next = occ_reg;
        if (push && !pop) begin
            occ_next = occ_reg + OCC_ONE;
        end else if (!push && pop) begin
            occ_next = occ_reg - OCC_ONE;
        end
    end

    // Flush sequencing.
    // Flushes are only honoured in IDLE, and the decision uses the
    // post-cycle occupancy so a push in the flush cycle is drained too.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (flush_req) begin
                    state_next = (occ_next != '0) ? DRAIN : CLEAR;
                end
            end
            DRAIN: begin
                if (occ_next == '0) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, pointer and occupancy registers.
    // Reset wins over everything, and a low rdy_in freezes all of them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else if (rdy_in) begin
            state_reg <= state_next;
            occ_reg   <= occ_next;
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_reg_commit_ctrl.sv
// Self-checking bench for reg_commit_ctrl.
// This bench runs three phases:
//   1. a directed vector table with hand-computed expectations,
//   2. hand-written multi-cycle flush, stall and reset sequences,
//   3. a randomized run.
// Every cycle is also compared against a queue-based reference model.
module tb_reg_commit_ctrl;

    localparam int ROB_BIT = 4;
    localparam int DEPTH   = 4;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               rdy_in;
    logic               in_valid;
    logic [4:0]         in_reg_id;
    logic [31:0]        in_data;
    logic [ROB_BIT-1:0] in_rob_entry;
    logic               in_ready;
    logic               flush_req;
    logic               rob_commit;
    logic [4:0]         commit_reg_id;
    logic [31:0]        commit_reg_data;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic               rob_clear_up;
    logic               issue_stall;
    logic               flush_done;
    logic [2:0]         occupancy;

    always #5 clk_in = ~clk_in;

    reg_commit_ctrl #(
        .ROB_BIT(ROB_BIT),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .in_valid        (in_valid),
        .in_reg_id       (in_reg_id),
        .in_data         (in_data),
        .in_rob_entry    (in_rob_entry),
        .in_ready        (in_ready),
        .flush_req       (flush_req),
        .rob_commit      (rob_commit),
        .commit_reg_id   (commit_reg_id),
        .commit_reg_data (commit_reg_data),
        .commit_rob_entry(commit_rob_entry),
        .rob_clear_up    (rob_clear_up),
        .issue_stall     (issue_stall),
        .flush_done      (flush_done),
        .occupancy       (occupancy)
    );

    typedef struct {
        bit          chk_tbl;
        bit          rst;
        bit          rdy;
        bit          valid;
        logic [4:0]  id;
        logic [31:0] data;
        logic [3:0]  tag;
        bit          flush;
        bit          e_ready;
        bit          e_commit;
        logic [4:0]  e_id;
        logic [31:0] e_data;
        logic [3:0]  e_tag;
        bit          e_clear;
        bit          e_stall;
        logic [2:0]  e_occ;
    } vec_t;

    typedef struct {
        logic [4:0]  id;
        logic [31:0] data;
        logic [3:0]  tag;
    } ent_t;

    typedef enum int {M_IDLE, M_DRAIN, M_CLEAR} mode_t;

    // Reference model: the queue contents plus the flush phase.
    ent_t  mq[$];
    mode_t mode;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input bit rst, input bit rdy, input bit valid, input logic [4:0] id,
                                input logic [31:0] data, input logic [3:0] tag, input bit flush);
        vec_t v;
        v          = '{default: '0};
        v.rst      = rst;
        v.rdy      = rdy;
        v.valid    = valid;
        v.id       = id;
        v.data     = data;
        v.tag      = tag;
        v.flush    = flush;
        return v;
    endfunction

    function automatic vec_t mkt(input bit rdy, input bit valid, input logic [4:0] id,
                                 input logic [31:0] data, input logic [3:0] tag, input bit flush,
                                 input bit e_ready, input bit e_commit, input logic [4:0] e_id,
                                 input logic [31:0] e_data, input logic [3:0] e_tag,
                                 input bit e_clear, input bit e_stall, input logic [2:0] e_occ);
        vec_t v;
        v          = mk(1'b0, rdy, valid, id, data, tag, flush);
        v.chk_tbl  = 1'b1;
        v.e_ready  = e_ready;
        v.e_commit = e_commit;
        v.e_id     = e_id;
        v.e_data   = e_data;
        v.e_tag    = e_tag;
        v.e_clear  = e_clear;
        v.e_stall  = e_stall;
        v.e_occ    = e_occ;
        return v;
    endfunction

    // One clock cycle: drive, check outputs mid-cycle, then advance the model.
    task automatic run_cycle(input vec_t v);
        bit   m_ready;
        bit   m_commit;
        bit   m_clear;
        bit   m_stall;
        ent_t m_head;
        @(negedge clk_in);
        rst_in       = v.rst;
        rdy_in       = v.rdy;
        in_valid     = v.valid;
        in_reg_id    = v.id;
        in_data      = v.data;
        in_rob_entry = v.tag;
        flush_req    = v.flush;
        #1;
        m_ready  = v.rdy && (mode == M_IDLE) && (mq.size() < DEPTH);
        m_commit = v.rdy && (mq.size() != 0) && (mode != M_CLEAR);
        m_clear  = v.rdy && (mode == M_CLEAR);
        m_stall  = (mode != M_IDLE);
        m_head   = '{id: 5'd0, data: 32'd0, tag: 4'd0};
        if (m_commit) begin
            m_head = mq[0];
        end

        $display("cyc %0d rst=%0b rdy=%0b vld=%0b id=%0d flush=%0b | rdy_o=%0b commit=%0b id=%0d data=%08h tag=%0d clr=%0b done=%0b stall=%0b occ=%0d",
                 cyc, v.rst, v.rdy, v.valid, v.id, v.flush, in_ready, rob_commit, commit_reg_id,
                 commit_reg_data, commit_rob_entry, rob_clear_up, flush_done, issue_stall, occupancy);

        chk("model_in_ready", 32'(in_ready), 32'(m_ready));
        chk("model_rob_commit", 32'(rob_commit), 32'(m_commit));
        chk("model_commit_reg_id", 32'(commit_reg_id), 32'(m_head.id));
        chk("model_commit_reg_data", commit_reg_data, m_head.data);
        chk("model_commit_rob_entry", 32'(commit_rob_entry), 32'(m_head.tag));
        chk("model_rob_clear_up", 32'(rob_clear_up), 32'(m_clear));
        chk("model_flush_done", 32'(flush_done), 32'(m_clear));
        chk("model_issue_stall", 32'(issue_stall), 32'(m_stall));
        chk("model_occupancy", 32'(occupancy), 32'(mq.size()));

        if (v.chk_tbl) begin
            chk("tbl_in_ready", 32'(in_ready), 32'(v.e_ready));
            chk("tbl_rob_commit", 32'(rob_commit), 32'(v.e_commit));
            chk("tbl_commit_reg_id", 32'(commit_reg_id), 32'(v.e_id));
            chk("tbl_commit_reg_data", commit_reg_data, v.e_data);
            chk("tbl_commit_rob_entry", 32'(commit_rob_entry), 32'(v.e_tag));
            chk("tbl_rob_clear_up", 32'(rob_clear_up), 32'(v.e_clear));
            chk("tbl_flush_done", 32'(flush_done), 32'(v.e_clear));
            chk("tbl_issue_stall", 32'(issue_stall), 32'(v.e_stall));
            chk("tbl_occupancy", 32'(occupancy), 32'(v.e_occ));
        end

        // Advance the model according to the rules for this cycle.
        if (v.rst) begin
            mq.delete();
            mode = M_IDLE;
        end else if (v.rdy) begin
            if (m_commit) begin
                void'(mq.pop_front());
            end
            if (v.valid && m_ready && (v.id != 5'd0)) begin
                mq.push_back('{id: v.id, data: v.data, tag: v.tag});
            end
            case (mode)
                M_IDLE:  if (v.flush) mode = (mq.size() != 0) ? M_DRAIN : M_CLEAR;
                M_DRAIN: if (mq.size() == 0) mode = M_CLEAR;
                default: mode = M_IDLE;
            endcase
        end
        cyc++;
    endtask

    initial begin
        // Directed vectors, starting from a freshly reset, empty queue.
        tbl[0]  = mkt(1, 0, 0, 32'h0,        0, 0,  1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[1]  = mkt(1, 1, 5, 32'h1234,     3, 0,  1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[2]  = mkt(1, 0, 0, 32'h0,        0, 0,  1, 1, 5, 32'h1234,     3, 0, 0, 1);
        tbl[3]  = mkt(1, 0, 0, 32'h0,        0, 0,  1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[4]  = mkt(1, 1, 0, 32'hDEAD,     7, 0,  1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[5]  = mkt(1, 0, 0, 32'h0,        0, 0,  1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[6]  = mkt(1, 1, 7, 32'hAAAA5555, 9, 0,  1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[7]  = mkt(1, 1, 8, 32'h0BADF00D, 1, 0,  1, 1, 7, 32'hAAAA5555, 9, 0, 0, 1);
        tbl[8]  = mkt(0, 1, 9, 32'h99,       2, 0,  0, 0, 0, 32'h0,        0, 0, 0, 1);
        tbl[9]  = mkt(1, 0, 0, 32'h0,        0, 0,  1, 1, 8, 32'h0BADF00D, 1, 0, 0, 1);
        tbl[10] = mkt(1, 0, 0, 32'h0,        0, 1,  1, 0, 0, 32'h0,        0, 0, 0, 0);
        tbl[11] = mkt(1, 0, 0, 32'h0,        0, 0,  0, 0, 0, 32'h0,        0, 1, 1, 0);
        tbl[12] = mkt(1, 0, 0, 32'h0,        0, 0,  1, 0, 0, 32'h0,        0, 0, 0, 0);

        rst_in       = 1'b1;
        rdy_in       = 1'b0;
        in_valid     = 1'b0;
        in_reg_id    = '0;
        in_data      = '0;
        in_rob_entry = '0;
        flush_req    = 1'b0;
        repeat (2) @(posedge clk_in);
        mq.delete();
        mode = M_IDLE;

        for (int i = 0; i < 13; i++) begin
            run_cycle(tbl[i]);
        end

        // Flush with a push in the same cycle.
        // Also checks that rdy_in low holds CLEAR,
        // and that flush_req is ignored outside IDLE.
        run_cycle(mk(0, 1, 1, 5'd3,  32'h33, 4'd3, 0));
        run_cycle(mk(0, 1, 1, 5'd4,  32'h44, 4'd4, 1));
        run_cycle(mk(0, 1, 0, 5'd0,  32'h0,  4'd0, 1));
        run_cycle(mk(0, 0, 0, 5'd0,  32'h0,  4'd0, 0));
        run_cycle(mk(0, 1, 0, 5'd0,  32'h0,  4'd0, 1));
        run_cycle(mk(0, 1, 0, 5'd0,  32'h0,  4'd0, 0));

        // rdy_in is low for three cycles in the middle of a drain, then draining resumes.
        run_cycle(mk(0, 1, 1, 5'd10, 32'hA0, 4'd10, 0));
        run_cycle(mk(0, 1, 1, 5'd11, 32'hB0, 4'd11, 1));
        for (int i = 0; i < 3; i++) begin
            run_cycle(mk(0, 0, 1, 5'd20, 32'hC0, 4'd5, 0));
        end
        run_cycle(mk(0, 1, 0, 5'd0,  32'h0,  4'd0, 0));
        run_cycle(mk(0, 1, 0, 5'd0,  32'h0,  4'd0, 0));
        run_cycle(mk(0, 1, 0, 5'd0,  32'h0,  4'd0, 0));

        // Reset during a drain, while rdy_in is low.
        // The controller must return to IDLE and empty, with no clear pulse.
        run_cycle(mk(0, 1, 1, 5'd12, 32'hD0, 4'd12, 0));
        run_cycle(mk(0, 1, 1, 5'd13, 32'hE0, 4'd13, 1));
        run_cycle(mk(1, 0, 0, 5'd0,  32'h0,  4'd0,  0));
        run_cycle(mk(0, 1, 0, 5'd0,  32'h0,  4'd0,  0));
        run_cycle(mk(0, 1, 1, 5'd14, 32'hF0, 4'd14, 0));
        run_cycle(mk(0, 1, 0, 5'd0,  32'h0,  4'd0,  0));

        // Randomized traffic with occasional flushes, stalls and resets.
        for (int i = 0; i < 3000; i++) begin
            run_cycle(mk($urandom_range(0, 99) < 2,
                         $urandom_range(0, 99) < 85,
                         $urandom_range(0, 99) < 65,
                         ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                         $urandom,
                         4'($urandom_range(0, 15)),
                         $urandom_range(0, 99) < 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
